// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared select codes, shadow-entry type and tag-match helper
package mips_hazard_pkg;
  localparam int TAG_W = 8;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic [TAG_W-1:0] write_reg;
  } tag_entry_t;
  function automatic logic tag_match(tag_entry_t e, logic [TAG_W-1:0] src);
    return e.valid && e.reg_write && (e.write_reg != '0) && (e.write_reg == src);
  endfunction
endpackage

// File: rtl/dest_tag_stage.sv
// dest_tag_stage: one shadow destination-tag entry with load, clear and hold
module dest_tag_stage
  import mips_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  tag_entry_t d,
  output tag_entry_t q
);
  // clear beats load; neither means hold
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: EX operand-forward selects plus load-use/flush pipeline control (FORWARDING_EN enables forwarding)
module forwarding_hazard_unit
  import mips_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Freeze,
  input  logic                  Flush,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_WriteReg,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IDEX_Bubble
);
  logic [TAG_W-1:0] rs, rt;
  tag_entry_t id_tag, ex_q, mem_q;
  logic a_ex, a_mem, b_ex, b_mem, hazard, stall, accept;
  logic unused_tag;
  assign rs = TAG_W'(ID_Rs);
  assign rt = TAG_W'(ID_Rt);
  assign id_tag = '{valid: 1'b1, reg_write: ID_RegWrite, mem_read: ID_MemRead,
                    write_reg: TAG_W'(ID_WriteReg)};
  assign a_ex = ID_UsesRs && tag_match(ex_q, rs);
  assign b_ex = ID_UsesRt && tag_match(ex_q, rt);
  assign a_mem = ID_UsesRs && tag_match(mem_q, rs);
  assign b_mem = ID_UsesRt && tag_match(mem_q, rt);
`ifdef FORWARDING_EN
  assign hazard = ex_q.mem_read && (a_ex || b_ex);
`else
  assign hazard = a_ex || b_ex || a_mem || b_mem;
`endif
  assign stall = ID_Valid && !Flush && !Freeze && hazard;
  assign accept = ID_Valid && !stall && !Flush;
  assign PCWrite = !Freeze && (Flush || !stall);
  assign IFIDWrite = !Freeze && (Flush || !stall);
  assign IDEX_Bubble = !Freeze && (Flush || stall);
  assign unused_tag = mem_q.mem_read;
  dest_tag_stage u_ex (
    .clk  (clk),
    .rst  (reset),
    .load (!Freeze && accept),
    .clr  (!Freeze && !accept),
    .d    (id_tag),
    .q    (ex_q)
  );
  dest_tag_stage u_mem (
    .clk  (clk),
    .rst  (reset),
    .load (!Freeze),
    .clr  (1'b0),
    .d    (ex_q),
    .q    (mem_q)
  );
`ifdef FORWARDING_EN
  logic [1:0] sel_a, sel_b;
  assign sel_a = a_ex ? FWD_EXMEM : a_mem ? FWD_MEMWB : FWD_REGFILE;
  assign sel_b = b_ex ? FWD_EXMEM : b_mem ? FWD_MEMWB : FWD_REGFILE;
  // selects resolved in ID and held through the consumer's EX cycle
  always_ff @(posedge clk)
    if (reset) begin
      ForwardA <= FWD_REGFILE;
      ForwardB <= FWD_REGFILE;
    end else if (!Freeze) begin
      ForwardA <= accept ? sel_a : FWD_REGFILE;
      ForwardB <= accept ? sel_b : FWD_REGFILE;
    end
`else
  assign ForwardA = FWD_REGFILE;
  assign ForwardB = FWD_REGFILE;
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: scoreboard bench with an instruction-level pipeline model
module tb_forwarding_hazard_unit;
  logic clk = 1'b0;
  logic reset, Freeze, Flush, ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead;
  logic [4:0] ID_Rs, ID_Rt, ID_WriteReg;
  logic [1:0] ForwardA, ForwardB;
  logic PCWrite, IFIDWrite, IDEX_Bubble;
  always #5 clk = ~clk;
  forwarding_hazard_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .Freeze(Freeze), .Flush(Flush), .ID_Valid(ID_Valid),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_WriteReg(ID_WriteReg),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IDEX_Bubble(IDEX_Bubble)
  );
  typedef struct {bit v; bit wr; bit ld; int rd;} ins_t;
  typedef struct {logic [2:0] ctrl; logic [3:0] fwd; int cyc;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  ins_t pipe [2];
  int fa = 0, fb = 0;
  bit last_hold = 0;
  // nearest in-flight producer of s: 0 = instruction in EX, 1 = in MEM, -1 = none
  function automatic int producer(int s, bit used);
    for (int d = 0; d < 2; d++)
      if (used && s != 0 && pipe[d].v && pipe[d].wr && pipe[d].rd == s) return d;
    return -1;
  endfunction
  task automatic step();
    int da, db;
    bit haz, stall, acc;
    ins_t cur;
    exp_t e;
    da = producer(int'(ID_Rs), ID_UsesRs);
    db = producer(int'(ID_Rt), ID_UsesRt);
`ifdef FORWARDING_EN
    haz = pipe[0].ld && (da == 0 || db == 0);
`else
    haz = (da >= 0) || (db >= 0);
`endif
    stall = ID_Valid && !Flush && !Freeze && haz;
    acc = ID_Valid && !stall && !Flush;
    e.ctrl = Freeze ? 3'b000 : Flush ? 3'b111 : stall ? 3'b001 : 3'b110;
    e.fwd = {fa[1:0], fb[1:0]};
    e.cyc = cyc;
    sb.push_back(e);
    last_hold = !e.ctrl[1];
    cur = '{acc, acc && ID_RegWrite, acc && ID_MemRead, acc ? int'(ID_WriteReg) : 0};
    @(posedge clk);
    cyc++;
    if (reset) begin
      pipe[0] = '{0, 0, 0, 0};
      pipe[1] = '{0, 0, 0, 0};
      fa = 0;
      fb = 0;
    end else if (!Freeze) begin
      pipe[1] = pipe[0];
      pipe[0] = cur;
`ifdef FORWARDING_EN
      fa = (acc && da >= 0) ? da + 1 : 0;
      fb = (acc && db >= 0) ? db + 1 : 0;
`endif
    end
    #1;
  endtask
  task automatic instr(int rs, bit ur, int rt, bit ut, bit wr, bit ld, int wd);
    ID_Valid = 1'b1;
    ID_Rs = 5'(rs);
    ID_UsesRs = ur;
    ID_Rt = 5'(rt);
    ID_UsesRt = ut;
    ID_RegWrite = wr;
    ID_MemRead = ld;
    ID_WriteReg = 5'(wd);
    step();
  endtask
  task automatic nop();
    ID_Valid = 1'b0;
    ID_UsesRs = 1'b0;
    ID_UsesRt = 1'b0;
    ID_RegWrite = 1'b0;
    ID_MemRead = 1'b0;
    step();
  endtask
  task automatic retry(int rs, bit ur, int rt, bit ut, bit wr, bit ld, int wd);
    for (int k = 0; k < 4; k++) begin
      instr(rs, ur, rt, ut, wr, ld, wd);
      if (!last_hold) break;
    end
  endtask
  // monitor: every cycle the DUT presents its control and select outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({PCWrite, IFIDWrite, IDEX_Bubble} !== e.ctrl) begin
          bad++;
          $display("FAIL ctrl cyc=%0d got pc/ifid/bub=%b want=%b", e.cyc,
                   {PCWrite, IFIDWrite, IDEX_Bubble}, e.ctrl);
        end
        total++;
        if ({ForwardA, ForwardB} !== e.fwd) begin
          bad++;
          $display("FAIL fwd cyc=%0d got A/B=%b want=%b", e.cyc, {ForwardA, ForwardB}, e.fwd);
        end
      end
    end
  end
  initial begin
    pipe[0] = '{0, 0, 0, 0};
    pipe[1] = '{0, 0, 0, 0};
    reset = 1'b1; Freeze = 1'b0; Flush = 1'b0; ID_Valid = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_WriteReg = '0;
    @(posedge clk);
    #1;
    nop();
    nop();
    reset = 1'b0;
    instr(1, 1, 2, 1, 1, 0, 3);
    instr(3, 1, 5, 1, 1, 0, 4);
    nop(); nop(); nop();
    instr(1, 1, 2, 1, 1, 0, 3);
    nop();
    retry(7, 1, 3, 1, 1, 0, 6);
    nop(); nop(); nop();
    instr(9, 1, 0, 0, 1, 1, 8);
    retry(8, 1, 8, 1, 1, 0, 10);
    nop(); nop(); nop();
    instr(1, 1, 2, 1, 1, 0, 0);
    instr(0, 1, 0, 1, 1, 0, 5);
    nop(); nop(); nop();
    instr(9, 1, 0, 0, 1, 1, 8);
    Flush = 1'b1;
    instr(8, 1, 8, 1, 1, 0, 10);
    Flush = 1'b0;
    nop(); nop(); nop();
    instr(1, 1, 2, 1, 1, 0, 3);
    Freeze = 1'b1;
    repeat (3) instr(3, 1, 3, 1, 1, 0, 4);
    Freeze = 1'b0;
    retry(3, 1, 3, 1, 1, 0, 4);
    nop(); nop(); nop();
    instr(9, 1, 0, 0, 1, 1, 8);
    instr(8, 1, 8, 1, 1, 0, 10);
    reset = 1'b1;
    instr(8, 1, 8, 1, 1, 0, 10);
    reset = 1'b0;
    nop(); nop();
    for (int i = 0; i < 600; i++) begin
      if (!last_hold) begin
        ID_Valid = $urandom_range(0, 9) != 0;
        ID_Rs = 5'($urandom_range(0, 7));
        ID_Rt = 5'($urandom_range(0, 7));
        ID_UsesRs = 1'($urandom);
        ID_UsesRt = 1'($urandom);
        ID_RegWrite = $urandom_range(0, 3) != 0;
        ID_MemRead = $urandom_range(0, 2) == 0;
        ID_WriteReg = 5'($urandom_range(0, 7));
      end
      Flush = $urandom_range(0, 9) == 0;
      Freeze = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    reset = 1'b0; Flush = 1'b0; Freeze = 1'b0;
    nop();
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
